// File: rtl/write_back_stage.sv
// -----------------------------------------------------------------------------
// write_back_stage
// Final (W) stage of the five-stage RV32I pipeline.
//  - Captures the M-stage bundle plus RAM read data when W can accept.
//  - Selects the write-back value and drives the register-file write port.
//    The write port is combinational from the W registers, so the same-cycle
//    bypass network can use it.
//  - Presents the retiring instruction on the commit interface.
//  - Keeps the retirement and branch-prediction statistics counters.
//  - Detects a retired ebreak and freezes the pipeline with a sticky halt.
// Ports:
//  clk, rst                       clock, synchronous active-high reset
//  m_to_w_valid / w_allow_in      handshake with the M stage
//  w_valid                        W holds a valid instruction
//  m_valM, M_*                    M-stage bundle and RAM read data
//  wb_en, wb_rd, wb_data          register-file write port and bypass source
//  W_cur_pc, W_instr, W_pred_pc,  commit/difftest interface
//  W_commit
//  halt                           sticky, set one edge after ebreak retires
//  cnt_cycle, cnt_instret,        statistics counters, CNT_W bits, wrapping
//  cnt_ctrl, cnt_mispred
// -----------------------------------------------------------------------------
module write_back_stage #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m_to_w_valid,
    output logic             w_allow_in,
    output logic             w_valid,
    input  logic [31:0]      m_valM,
    input  logic [6:0]       M_opcode,
    input  logic [9:0]       M_funct,
    input  logic [31:0]      M_valE,
    input  logic [4:0]       M_rd,
    input  logic [31:0]      M_default_pc,
    input  logic [31:0]      M_cur_pc,
    input  logic [31:0]      M_instr,
    input  logic             M_commit,
    input  logic [31:0]      M_pred_pc,
    input  logic [31:0]      M_predicted_pc,
    output logic             wb_en,
    output logic [4:0]       wb_rd,
    output logic [31:0]      wb_data,
    output logic [31:0]      W_cur_pc,
    output logic [31:0]      W_instr,
    output logic [31:0]      W_pred_pc,
    output logic             W_commit,
    output logic             halt,
    output logic [CNT_W-1:0] cnt_cycle,
    output logic [CNT_W-1:0] cnt_instret,
    output logic [CNT_W-1:0] cnt_ctrl,
    output logic [CNT_W-1:0] cnt_mispred
);

    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_S      = 7'b0100011;
    localparam logic [6:0]  OP_B      = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_I      = 7'b0010011;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [31:0] EBREAK    = 32'h00100073;

    logic             w_valid_r;
    logic             halt_r;
    logic [6:0]       w_opcode_r;
    logic [9:0]       w_funct_r;
    logic [31:0]      w_val_e_r;
    logic [31:0]      w_val_m_r;
    logic [4:0]       w_rd_r;
    logic [31:0]      w_default_pc_r;
    logic [31:0]      w_cur_pc_r;
    logic [31:0]      w_instr_r;
    logic             w_commit_r;
    logic [31:0]      w_pred_pc_r;
    logic [31:0]      w_predicted_pc_r;
    logic [CNT_W-1:0] cnt_cycle_r;
    logic [CNT_W-1:0] cnt_instret_r;
    logic [CNT_W-1:0] cnt_ctrl_r;
    logic [CNT_W-1:0] cnt_mispred_r;

    logic             allow_in_s;
    logic             capture_s;
    logic             ret_s;
    logic             is_ctrl_s;
    logic             writes_s;
    logic [31:0]      sel_data_s;
    logic             wb_en_s;
    logic             unused_funct_s;

    // funct is carried with the bundle for observability but no W decision uses it
    assign unused_funct_s = ^w_funct_r;

    // Once halted the stage never drains, so a held instruction blocks M
    assign allow_in_s = ~w_valid_r | ~halt_r;
    assign capture_s  = allow_in_s & m_to_w_valid;
    assign ret_s      = w_valid_r & w_commit_r & ~halt_r;
    assign is_ctrl_s  = (w_opcode_r == OP_B) | (w_opcode_r == OP_JAL) |
                        (w_opcode_r == OP_JALR);

    // Write-back value select by opcode class
    always_comb begin
        writes_s   = 1'b0;
        sel_data_s = 32'h0000_0000;
        case (w_opcode_r)
            OP_LOAD: begin
                writes_s   = 1'b1;
                sel_data_s = w_val_m_r;
            end
            OP_JAL, OP_JALR: begin
                writes_s   = 1'b1;
                sel_data_s = w_default_pc_r;
            end
            OP_R, OP_I, OP_LUI, OP_AUIPC: begin
                writes_s   = 1'b1;
                sel_data_s = w_val_e_r;
            end
            default: begin
                writes_s   = 1'b0;
                sel_data_s = 32'h0000_0000;
            end
        endcase
    end

    // Register-file write enable; x0 writes and halted state suppressed
    always_comb begin
        wb_en_s = 1'b0;
        if (w_valid_r && writes_s && (w_rd_r != 5'd0) && !halt_r) begin
            wb_en_s = 1'b1;
        end else begin
            wb_en_s = 1'b0;
        end
    end

    // Control state: valid flag, sticky halt and statistics counters
    always_ff @(posedge clk) begin
        if (rst) begin
            w_valid_r     <= 1'b0;
            halt_r        <= 1'b0;
            cnt_cycle_r   <= {CNT_W{1'b0}};
            cnt_instret_r <= {CNT_W{1'b0}};
            cnt_ctrl_r    <= {CNT_W{1'b0}};
            cnt_mispred_r <= {CNT_W{1'b0}};
        end else begin
            if (allow_in_s) begin
                w_valid_r <= m_to_w_valid;
            end
            if (ret_s && (w_instr_r == EBREAK)) begin
                halt_r <= 1'b1;
            end
            if (!halt_r) begin
                cnt_cycle_r <= cnt_cycle_r + CNT_W'(1);
            end
            if (ret_s) begin
                cnt_instret_r <= cnt_instret_r + CNT_W'(1);
                if (is_ctrl_s) begin
                    cnt_ctrl_r <= cnt_ctrl_r + CNT_W'(1);
                    if (w_pred_pc_r != w_predicted_pc_r) begin
                        cnt_mispred_r <= cnt_mispred_r + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Data capture from M; these registers intentionally carry no reset
    always_ff @(posedge clk) begin
        if (capture_s) begin
            w_opcode_r       <= M_opcode;
            w_funct_r        <= M_funct;
            w_val_e_r        <= M_valE;
            w_val_m_r        <= m_valM;
            w_rd_r           <= M_rd;
            w_default_pc_r   <= M_default_pc;
            w_cur_pc_r       <= M_cur_pc;
            w_instr_r        <= M_instr;
            w_commit_r       <= M_commit;
            w_pred_pc_r      <= M_pred_pc;
            w_predicted_pc_r <= M_predicted_pc;
        end
    end

    assign w_allow_in  = allow_in_s;
    assign w_valid     = w_valid_r;
    assign halt        = halt_r;
    assign wb_en       = wb_en_s;
    assign wb_rd       = w_rd_r;
    assign wb_data     = wb_en_s ? sel_data_s : 32'h0000_0000;
    assign W_cur_pc    = w_cur_pc_r;
    assign W_instr     = w_instr_r;
    assign W_pred_pc   = w_pred_pc_r;
    assign W_commit    = w_commit_r;
    assign cnt_cycle   = cnt_cycle_r;
    assign cnt_instret = cnt_instret_r;
    assign cnt_ctrl    = cnt_ctrl_r;
    assign cnt_mispred = cnt_mispred_r;

endmodule

// File: tb/tb_write_back_stage.sv
module tb_write_back_stage;

    localparam int CNT_W = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             m_to_w_valid;
    logic             w_allow_in;
    logic             w_valid;
    logic [31:0]      m_valM;
    logic [6:0]       M_opcode;
    logic [9:0]       M_funct;
    logic [31:0]      M_valE;
    logic [4:0]       M_rd;
    logic [31:0]      M_default_pc;
    logic [31:0]      M_cur_pc;
    logic [31:0]      M_instr;
    logic             M_commit;
    logic [31:0]      M_pred_pc;
    logic [31:0]      M_predicted_pc;
    logic             wb_en;
    logic [4:0]       wb_rd;
    logic [31:0]      wb_data;
    logic [31:0]      W_cur_pc;
    logic [31:0]      W_instr;
    logic [31:0]      W_pred_pc;
    logic             W_commit;
    logic             halt;
    logic [CNT_W-1:0] cnt_cycle;
    logic [CNT_W-1:0] cnt_instret;
    logic [CNT_W-1:0] cnt_ctrl;
    logic [CNT_W-1:0] cnt_mispred;

    write_back_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .m_to_w_valid(m_to_w_valid), .w_allow_in(w_allow_in),
        .w_valid(w_valid), .m_valM(m_valM), .M_opcode(M_opcode), .M_funct(M_funct),
        .M_valE(M_valE), .M_rd(M_rd), .M_default_pc(M_default_pc), .M_cur_pc(M_cur_pc),
        .M_instr(M_instr), .M_commit(M_commit), .M_pred_pc(M_pred_pc),
        .M_predicted_pc(M_predicted_pc), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .W_cur_pc(W_cur_pc), .W_instr(W_instr), .W_pred_pc(W_pred_pc), .W_commit(W_commit),
        .halt(halt), .cnt_cycle(cnt_cycle), .cnt_instret(cnt_instret),
        .cnt_ctrl(cnt_ctrl), .cnt_mispred(cnt_mispred)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    typedef struct {
        logic [6:0]  op;
        logic [31:0] val_e;
        logic [31:0] val_m;
        logic [4:0]  rd;
        logic [31:0] dpc;
        logic        commit;
        logic [31:0] pred;
        logic [31:0] predicted;
        logic        exp_en;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[11];

    int passed = 0;
    int total  = 0;
    logic [CNT_W-1:0] exp_cycle, exp_instret, exp_ctrl, exp_mispred;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One clock; the cycle counter advances on edges taken out of reset
    // while not halted
    task automatic step(input logic halted);
        if (!rst && !halted) exp_cycle++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [31:0] val_e,
                         input logic [31:0] val_m, input logic [4:0] rd,
                         input logic [31:0] dpc, input logic [31:0] instr,
                         input logic commit, input logic [31:0] pred,
                         input logic [31:0] predicted);
        m_to_w_valid   = v;
        M_opcode       = op;
        M_funct        = 10'd0;
        M_valE         = val_e;
        m_valM         = val_m;
        M_rd           = rd;
        M_default_pc   = dpc;
        M_cur_pc       = dpc - 32'd4;
        M_instr        = instr;
        M_commit       = commit;
        M_pred_pc      = pred;
        M_predicted_pc = predicted;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, OP_I, 32'd0, 32'd0, 5'd0, 32'd4, 32'h13, 1'b0, 32'd0, 32'd0);
        step(1'b0);
        step(1'b0);
        exp_cycle = '0; exp_instret = '0; exp_ctrl = '0; exp_mispred = '0;
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{OP_I,     32'h1234,     32'h0,        5'd5,  32'h4,   1'b1, 32'h8,   32'h8,   1'b1, 32'h1234};
        vecs[1]  = '{OP_LOAD,  32'h80,       32'hDEADBEEF, 5'd7,  32'h8,   1'b1, 32'hC,   32'hC,   1'b1, 32'hDEADBEEF};
        vecs[2]  = '{OP_LOAD,  32'h80,       32'hDEADBEEF, 5'd0,  32'hC,   1'b1, 32'h10,  32'h10,  1'b0, 32'h0};
        vecs[3]  = '{OP_JAL,   32'h200,      32'h0,        5'd1,  32'h104, 1'b1, 32'h200, 32'h104, 1'b1, 32'h104};
        vecs[4]  = '{OP_S,     32'h90,       32'h55,       5'd3,  32'h204, 1'b1, 32'h208, 32'h208, 1'b0, 32'h0};
        vecs[5]  = '{OP_R,     32'h5555,     32'h0,        5'd10, 32'h208, 1'b1, 32'h20C, 32'h20C, 1'b1, 32'h5555};
        vecs[6]  = '{OP_LUI,   32'hABCDE000, 32'h0,        5'd31, 32'h20C, 1'b1, 32'h210, 32'h210, 1'b1, 32'hABCDE000};
        vecs[7]  = '{OP_B,     32'h0,        32'h0,        5'd2,  32'h210, 1'b1, 32'h300, 32'h300, 1'b0, 32'h0};
        vecs[8]  = '{OP_JALR,  32'h400,      32'h0,        5'd2,  32'h304, 1'b1, 32'h400, 32'h500, 1'b1, 32'h304};
        vecs[9]  = '{OP_AUIPC, 32'h1000,     32'h0,        5'd4,  32'h404, 1'b1, 32'h408, 32'h408, 1'b1, 32'h1000};
        vecs[10] = '{OP_I,     32'h77,       32'h0,        5'd6,  32'h408, 1'b0, 32'h40C, 32'h40C, 1'b1, 32'h77};

        // Reset state
        do_reset();
        chk("rst_w_valid", w_valid, 1'b0);
        chk("rst_halt", halt, 1'b0);
        chk("rst_wb_en", wb_en, 1'b0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_allow_in", w_allow_in, 1'b1);
        chk("rst_cnt_cycle", cnt_cycle, 64'd0);
        chk("rst_cnt_instret", cnt_instret, 64'd0);
        chk("rst_cnt_ctrl", cnt_ctrl, 64'd0);
        chk("rst_cnt_mispred", cnt_mispred, 64'd0);

        // Table-driven back-to-back instructions
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].val_e, vecs[i].val_m, vecs[i].rd,
                  vecs[i].dpc, 32'h13, vecs[i].commit, vecs[i].pred, vecs[i].predicted);
            step(1'b0);
            chk($sformatf("v%0d_w_valid", i), w_valid, 1'b1);
            chk($sformatf("v%0d_wb_en", i), wb_en, vecs[i].exp_en);
            chk($sformatf("v%0d_wb_data", i), wb_data, vecs[i].exp_data);
            if (vecs[i].exp_en) chk($sformatf("v%0d_wb_rd", i), wb_rd, vecs[i].rd);
            chk($sformatf("v%0d_instret", i), cnt_instret, exp_instret);
            chk($sformatf("v%0d_mispred", i), cnt_mispred, exp_mispred);
            // Model: this instruction retires at the coming edge
            if (vecs[i].commit) begin
                exp_instret++;
                if (vecs[i].op == OP_B || vecs[i].op == OP_JAL || vecs[i].op == OP_JALR) begin
                    exp_ctrl++;
                    if (vecs[i].pred != vecs[i].predicted) exp_mispred++;
                end
            end
        end
        drive(1'b0, OP_I, 32'hFFFF, 32'h0, 5'd9, 32'h0, 32'h13, 1'b1, 32'h0, 32'h0);
        step(1'b0);
        chk("tbl_bubble_valid", w_valid, 1'b0);
        chk("tbl_bubble_wb_en", wb_en, 1'b0);
        chk("tbl_instret", cnt_instret, exp_instret);
        chk("tbl_instret_abs", cnt_instret, 64'd10);
        chk("tbl_ctrl", cnt_ctrl, 64'd3);
        chk("tbl_mispred", cnt_mispred, 64'd2);
        chk("tbl_cycle", cnt_cycle, exp_cycle);

        // Four valid instructions then two bubbles
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, OP_I, 32'h100 + i, 32'h0, 5'd8 + 5'(i), 32'h4, 32'h13, 1'b1, 32'h0, 32'h0);
            step(1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, OP_I, 32'hBAD, 32'h0, 5'd9, 32'h4, 32'h13, 1'b1, 32'h0, 32'h0);
            step(1'b0);
            chk($sformatf("bub%0d_wb_en", i), wb_en, 1'b0);
            chk($sformatf("bub%0d_valid", i), w_valid, 1'b0);
        end
        chk("b2b_instret", cnt_instret, 64'd4);
        chk("b2b_cycle", cnt_cycle, 64'd6);
        chk("b2b_cycle_model", cnt_cycle, exp_cycle);

        // ebreak then ADD: halt freezes the stage
        do_reset();
        drive(1'b1, OP_SYS, 32'h0, 32'h0, 5'd0, 32'h24, 32'h00100073, 1'b1, 32'h24, 32'h24);
        step(1'b0);
        chk("ebk_valid", w_valid, 1'b1);
        chk("ebk_halt_pre", halt, 1'b0);
        chk("ebk_wb_en", wb_en, 1'b0);
        chk("ebk_instr", W_instr, 32'h00100073);
        drive(1'b1, OP_R, 32'h99, 32'h0, 5'd9, 32'h28, 32'h00000033, 1'b1, 32'h28, 32'h28);
        step(1'b0);
        chk("hlt_halt", halt, 1'b1);
        chk("hlt_allow_in", w_allow_in, 1'b0);
        chk("hlt_wb_en", wb_en, 1'b0);
        chk("hlt_wb_data", wb_data, 32'h0);
        chk("hlt_instret", cnt_instret, 64'd1);
        chk("hlt_cycle", cnt_cycle, 64'd2);
        drive(1'b1, OP_I, 32'h55, 32'h0, 5'd12, 32'h2C, 32'h13, 1'b1, 32'h2C, 32'h2C);
        step(1'b1);
        step(1'b1);
        chk("frz_halt", halt, 1'b1);
        chk("frz_instret", cnt_instret, 64'd1);
        chk("frz_cycle", cnt_cycle, 64'd2);
        chk("frz_wb_en", wb_en, 1'b0);
        chk("frz_instr_held", W_instr, 32'h00000033);
        rst = 1'b1;
        step(1'b1);
        chk("rst2_halt", halt, 1'b0);
        chk("rst2_valid", w_valid, 1'b0);
        chk("rst2_allow_in", w_allow_in, 1'b1);
        chk("rst2_cycle", cnt_cycle, 64'd0);
        chk("rst2_instret", cnt_instret, 64'd0);
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/write_back_stage.md
# write_back_stage

Final (W) stage of the five-stage RV32I pipeline, directly downstream of the memory-access stage. Captures the M-stage bundle plus the RAM read data, selects the write-back value, drives the register-file write port and bypass network, and presents the retiring instruction to the commit/difftest interface. Also maintains retirement and branch-prediction statistics counters and detects `ebreak` to halt the pipeline.

## Interface
Parameters:
- CNT_W, 64, width of every statistics counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- m_to_w_valid  in  1  M stage has a valid instruction for W
- w_allow_in  out  1  W can accept this cycle
- w_valid  out  1  W holds a valid instruction
- m_valM  in  32  RAM read data (already extended per funct), combinational from M registers
- M_opcode  in  7, M_funct in 10 ({funct7,funct3}), M_valE in 32, M_rd in 5, M_default_pc in 32 (pc+4)
- M_cur_pc  in  32, M_instr in 32, M_commit in 1, M_pred_pc in 32 (actual next pc), M_predicted_pc in 32
- wb_en  out  1  register-file write enable
- wb_rd  out  5  destination register
- wb_data  out  32  write data
- W_cur_pc / W_instr / W_pred_pc  out  32 each; W_commit out 1: commit interface
- halt  out  1  sticky, `ebreak` retired
- cnt_cycle, cnt_instret, cnt_ctrl, cnt_mispred  out  CNT_W each

## Operation
- W_ready_go = ~halt. w_allow_in = ~w_valid || W_ready_go.
- On clk: rst → w_valid=0; else if w_allow_in → w_valid<=m_to_w_valid.
- Capture when w_allow_in && m_to_w_valid: W_opcode, W_funct, W_valE, W_rd, W_default_pc, W_valM<=m_valM (sampled same cycle M drives its registers), W_cur_pc, W_instr, W_commit, W_pred_pc, W_predicted_pc. Data registers are not reset.
- Write-back select (combinational from W regs): OP_LOAD → W_valM; OP_JAL/OP_JALR → W_default_pc; OP_R, OP_I, OP_LUI, OP_AUIPC → W_valE; OP_S, OP_B, SYSTEM → no write.
- wb_en = w_valid && write-class opcode && W_rd!=0 && ~halt. wb_rd=W_rd; wb_data=selected value (0 when wb_en=0).
- Retire event: ret = w_valid && W_commit && ~halt (each W instruction retires exactly one cycle).
- Halt: ret && W_instr==32'h00100073 → halt<=1 next edge; cleared only by rst. The `ebreak` counts as retired. Once halt=1, w_allow_in=0 if w_valid (pipeline freezes), no further writes or counts.
- Counters (reset 0, wrap mod 2^CNT_W): cnt_cycle +1 every cycle while ~halt; cnt_instret +1 per ret; cnt_ctrl +1 per ret with opcode OP_B/OP_JAL/OP_JALR; cnt_mispred +1 per such ret with W_pred_pc != W_predicted_pc.

## Timing
- Reset values: w_valid=0, halt=0, all counters 0, wb_en=0, wb_data=0; W_* data outputs undefined until first capture.
- Latency: instruction in M at cycle n (m_to_w_valid=1) is in W at n+1; regfile written at end of n+1.
- wb_* combinational from W regs; usable for same-cycle bypass to D/E.
- Simultaneous capture and retire allowed every cycle (full throughput, no bubbles inserted by W).
- m_to_w_valid=0 with w_allow_in=1 → bubble: w_valid=0, no write, no count; cnt_cycle still increments.
- rst mid-operation overrides halt, capture and counting in the same edge.

## Test plan
- Reset: rst 2 cycles → w_valid=0, halt=0, wb_en=0, all counters 0, w_allow_in=1.
- ADDI x5 (OP_I, M_valE=32'h1234, rd=5) → next cycle wb_en=1, wb_rd=5, wb_data=32'h1234, cnt_instret=1.
- LW rd=7, m_valM=32'hDEADBEEF, M_valE=32'h80 → wb_data=32'hDEADBEEF; same with rd=0 → wb_en=0, instret still counts.
- JAL rd=1, M_default_pc=32'h104, M_pred_pc=32'h200, M_predicted_pc=32'h104 → wb_data=32'h104, cnt_ctrl+1, cnt_mispred+1; SW → wb_en=0.
- Back-to-back 4 valid instrs then 2 bubbles → instret=4, cycle counts all 6, no writes during bubbles.
- ebreak (instr 32'h00100073, commit=1) then valid ADD → halt=1 next cycle, w_allow_in=0, ADD never written, counters frozen; rst → all cleared.
